stage_3: RTL and testbench
==========================

STAGE_3 -- requirements
Module: stage_3

Interface
REQ-001 Parameters SHALL be: FLOAT_DATA_WIDTH, default 32, IEEE-754 single word width; ITER_WIDTH, default 5, iteration index width; STATE_WIDTH, default 2, state register width.
REQ-002 Ports SHALL be:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- clk_en  input  1  qualifies start.
- start  input  1  request one scaling operation.
- current_x  input  32  float x of current CORDIC iteration.
- current_y  input  32  float y of current CORDIC iteration.
- current_z  input  32  float residual angle z.
- iteration  input  5  iteration index i (0..31).
- val_1  output  32  registered -d*y*2^-i, feeds the downstream x-adder.
- val_2  output  32  registered +d*x*2^-i, feeds the downstream y-adder.
- dir  output  1  1 when d=+1, 0 when d=-1, for the z-path.
- done  output  1  one-cycle result-valid pulse.
- working  output  1  operation in progress.

Function
REQ-003 The FSM SHALL have states IDLE(00), CAPTURE(01), SCALE(10), DONE(11); any other encoding SHALL go to IDLE.
REQ-004 In IDLE, start=1 with clk_en=1 at edge N SHALL register current_x, current_y, current_z and iteration, and SHALL move to CAPTURE.
REQ-005 Otherwise IDLE SHALL hold state; start with clk_en=0 SHALL be ignored.
REQ-006 CAPTURE SHALL decode sign/exponent/mantissa and d, then go to SCALE; SCALE SHALL compute and register val_1, val_2 and dir, then go to DONE; DONE SHALL go to IDLE.
REQ-007 working SHALL be 1 in the cycles after edges N+1 and N+2 (CAPTURE, SCALE), and 0 otherwise.
REQ-008 val_1, val_2 and dir SHALL update at edge N+3; done SHALL be 1 for exactly the cycle after edge N+3.
REQ-009 Fixed latency SHALL be 3 cycles, start edge to done.
REQ-010 The block SHALL accept a start in the cycle after the done pulse (edge N+4); start in any non-IDLE state SHALL be ignored.
REQ-011 clk_en SHALL gate acceptance only; clk_en falling mid-operation SHALL NOT stall or abort the operation.
REQ-012 val_1, val_2 and dir SHALL hold their last result until the next operation writes them.
REQ-013 Direction: d=+1 (dir=1) when the z sign bit is 0 or the z exponent is 0 (zero/denormal); otherwise d=-1 (dir=0).
REQ-014 Scaling per operand (exponent e, mantissa m, sign s), with no multiplier or float IP, SHALL be:
- e==0: result 0x00000000.
- e==255 with m!=0 (NaN): result 0x7FC00000.
- e==255 with m==0 (inf): exponent kept, sign per REQ-015.
- 1<=e<=i: result 0x00000000 (flush).
- otherwise: exponent e-i, m unchanged, sign per REQ-015.
REQ-015 Output sign SHALL be: val_1 = s_y XOR dir; val_2 = s_x XOR ~dir.
REQ-016 Exponent subtraction SHALL use 9-bit unsigned arithmetic so that e-i never wraps.

Reset
REQ-017 rst=1 SHALL immediately, asynchronously, force: state IDLE; val_1=0, val_2=0, dir=0, done=0, working=0; all internal registers 0.
REQ-018 rst asserted mid-operation SHALL abort the operation with no done pulse.
REQ-019 After rst deasserts, the first start SHALL behave per REQ-004.

Verification
REQ-020 x=0x3F800000, y=0x3F000000, z=0x3E800000, i=1 -> val_1=0xBE800000, val_2=0x3F000000, dir=1, done exactly 3 cycles after start, working high 2 cycles.
REQ-021 x=0x40000000, y=0xBF800000, z=0xBE800000, i=3 -> val_1=0xBE000000, val_2=0xBE800000, dir=0.
REQ-022 x=0x02800000, z=0x00000000:
- i=5 -> val_2=0x00000000, dir=1.
- i=4 -> val_2=0x00800000, dir=1.
REQ-023 x=0x7F800000, y=0x7FC00001, z=0x3F800000, i=7 -> val_2=0x7F800000, val_1=0x7FC00000.
REQ-024 Start pulses in CAPTURE/SCALE/DONE, plus start with clk_en=0 in IDLE -> no extra done pulses; outputs change only per the accepted operation.
REQ-025 Back-to-back start at edge N+4 -> second done at edge N+7.
REQ-026 rst pulsed in SCALE -> all outputs 0 at once, no done pulse; next start completes normally with correct values.

Source files
------------

// File: rtl/stage_3.sv
// stage_3: one CORDIC scaling step. Captures x, y, z and the iteration index,
// then produces -d*y*2^-i and +d*x*2^-i by adjusting the float exponents
// directly (no multiplier, no float IP). It also produces the rotation
// direction d for the z-path. Fixed 3-cycle latency from the accepting edge
// to the done pulse.
module stage_3 #(
    parameter int FLOAT_DATA_WIDTH = 32,
    parameter int ITER_WIDTH       = 5,
    parameter int STATE_WIDTH      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic                        start,
    input  logic [FLOAT_DATA_WIDTH-1:0] current_x,
    input  logic [FLOAT_DATA_WIDTH-1:0] current_y,
    input  logic [FLOAT_DATA_WIDTH-1:0] current_z,
    input  logic [ITER_WIDTH-1:0]       iteration,
    output logic [FLOAT_DATA_WIDTH-1:0] val_1,
    output logic [FLOAT_DATA_WIDTH-1:0] val_2,
    output logic                        dir,
    output logic                        done,
    output logic                        working
);

    // Field layout of an IEEE-754 single: 1 sign, 8 exponent, rest mantissa.
    localparam int EXP_W = 8;
    localparam int MAN_W = FLOAT_DATA_WIDTH - EXP_W - 1;

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE    = STATE_WIDTH'(0),
        CAPTURE = STATE_WIDTH'(1),
        SCALE   = STATE_WIDTH'(2),
        DONE    = STATE_WIDTH'(3)
    } stateT;

    stateT                        state_q;

    // Raw operands latched on the accepting edge.
    logic [FLOAT_DATA_WIDTH-1:0]  xRaw_q;
    logic [FLOAT_DATA_WIDTH-1:0]  yRaw_q;
    logic [EXP_W:0]               zSignExp_q;
    logic [ITER_WIDTH-1:0]        iter_q;

    // Decoded fields and direction produced in CAPTURE.
    logic                         sx_q;
    logic [EXP_W-1:0]             ex_q;
    logic [MAN_W-1:0]             mx_q;
    logic                         sy_q;
    logic [EXP_W-1:0]             ey_q;
    logic [MAN_W-1:0]             my_q;
    logic                         dCap_q;
    logic                         dCap_d;

    // Scaled results produced in SCALE, published in DONE.
    logic [FLOAT_DATA_WIDTH-1:0]  res1_q;
    logic [FLOAT_DATA_WIDTH-1:0]  res2_q;
    logic                         resDir_q;
    logic [FLOAT_DATA_WIDTH-1:0]  res1_d;
    logic [FLOAT_DATA_WIDTH-1:0]  res2_d;

    // Registered outputs.
    logic [FLOAT_DATA_WIDTH-1:0]  val1_q;
    logic [FLOAT_DATA_WIDTH-1:0]  val2_q;
    logic                         dir_q;
    logic                         done_q;
    logic                         working_q;

    // Divide one float by 2^i through the exponent alone. The subtraction is
    // one bit wider than the exponent, so a borrow shows up in bit 8 instead
    // of wrapping; a borrow or a zero result means the value underflows and
    // is flushed to +0.
    function automatic logic [FLOAT_DATA_WIDTH-1:0] scaleOperand(
        input logic                  sgn,
        input logic [EXP_W-1:0]      e,
        input logic [MAN_W-1:0]      m,
        input logic [ITER_WIDTH-1:0] i
    );
        logic [EXP_W:0] diff;
        diff = {1'b0, e} - (EXP_W + 1)'(i);
        if (e == '0) begin
            return '0;
        end else if (e == {EXP_W{1'b1}}) begin
            if (m != '0) begin
                return {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
            end else begin
                return {sgn, {EXP_W{1'b1}}, m};
            end
        end else if (diff[EXP_W] || diff == '0) begin
            return '0;
        end else begin
            return {sgn, diff[EXP_W-1:0], m};
        end
    endfunction

    // Direction and scaled values computed from the decoded registers. d=+1
    // for a non-negative or zero/denormal residual angle.
    always_comb begin
        dCap_d = 1'b0;
        res1_d = '0;
        res2_d = '0;
        dCap_d = ~zSignExp_q[EXP_W] || (zSignExp_q[EXP_W-1:0] == '0);
        res1_d = scaleOperand(sy_q ^ dCap_q, ey_q, my_q, iter_q);
        res2_d = scaleOperand(sx_q ^ ~dCap_q, ex_q, mx_q, iter_q);
    end

    // Control FSM and all datapath registers; outputs are registered so done
    // and working never glitch, and clk_en only gates acceptance in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            xRaw_q     <= '0;
            yRaw_q     <= '0;
            zSignExp_q <= '0;
            iter_q     <= '0;
            sx_q       <= 1'b0;
            ex_q       <= '0;
            mx_q       <= '0;
            sy_q       <= 1'b0;
            ey_q       <= '0;
            my_q       <= '0;
            dCap_q     <= 1'b0;
            res1_q     <= '0;
            res2_q     <= '0;
            resDir_q   <= 1'b0;
            val1_q     <= '0;
            val2_q     <= '0;
            dir_q      <= 1'b0;
            done_q     <= 1'b0;
            working_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q    <= 1'b0;
                    working_q <= 1'b0;
                    if (start && clk_en) begin
                        xRaw_q     <= current_x;
                        yRaw_q     <= current_y;
                        zSignExp_q <= current_z[FLOAT_DATA_WIDTH-1 -: EXP_W + 1];
                        iter_q     <= iteration;
                        state_q    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    sx_q      <= xRaw_q[FLOAT_DATA_WIDTH-1];
                    ex_q      <= xRaw_q[FLOAT_DATA_WIDTH-2 -: EXP_W];
                    mx_q      <= xRaw_q[MAN_W-1:0];
                    sy_q      <= yRaw_q[FLOAT_DATA_WIDTH-1];
                    ey_q      <= yRaw_q[FLOAT_DATA_WIDTH-2 -: EXP_W];
                    my_q      <= yRaw_q[MAN_W-1:0];
                    dCap_q    <= dCap_d;
                    working_q <= 1'b1;
                    state_q   <= SCALE;
                end
                SCALE: begin
                    res1_q    <= res1_d;
                    res2_q    <= res2_d;
                    resDir_q  <= dCap_q;
                    working_q <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    val1_q    <= res1_q;
                    val2_q    <= res2_q;
                    dir_q     <= resDir_q;
                    done_q    <= 1'b1;
                    working_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    done_q    <= 1'b0;
                    working_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign val_1   = val1_q;
    assign val_2   = val2_q;
    assign dir     = dir_q;
    assign done    = done_q;
    assign working = working_q;

endmodule

// File: tb/tb_stage_3.sv
// tb_stage_3: directed and randomized checks of stage_3 against a field-level
// float model of "divide by 2^i, apply the CORDIC sign".
module tb_stage_3;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        start;
    logic [31:0] current_x;
    logic [31:0] current_y;
    logic [31:0] current_z;
    logic [4:0]  iteration;
    logic [31:0] val_1;
    logic [31:0] val_2;
    logic        dir;
    logic        done;
    logic        working;

    int checks = 0;
    int errors = 0;

    // Outputs the bench currently expects the DUT to be holding.
    logic [31:0] expV1 = 32'h0;
    logic [31:0] expV2 = 32'h0;
    logic        expDir = 1'b0;

    stage_3 dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .start     (start),
        .current_x (current_x),
        .current_y (current_y),
        .current_z (current_z),
        .iteration (iteration),
        .val_1     (val_1),
        .val_2     (val_2),
        .dir       (dir),
        .done      (done),
        .working   (working)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Reference: value w divided by 2^shift with its sign flipped by flip.
    function automatic logic [31:0] modelVal(input logic [31:0] w, input int shift,
                                             input logic flip);
        int   e;
        logic sgn;
        e   = int'(w[30:23]);
        sgn = w[31] ^ flip;
        if (e == 0) return 32'h0;
        if (e == 255) begin
            if (w[22:0] != 23'h0) return 32'h7FC00000;
            return {sgn, 8'hFF, 23'h0};
        end
        if (e - shift < 1) return 32'h0;
        return {sgn, 8'(e - shift), w[22:0]};
    endfunction

    // Random float biased towards zero, tiny, infinite and NaN exponents.
    function automatic logic [31:0] randFloat();
        logic [7:0]  e;
        logic [22:0] m;
        int          sel;
        sel = int'($urandom_range(0, 5));
        m   = 23'($urandom);
        case (sel)
            0:       e = 8'h00;
            1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) m = 23'h0; end
            2, 3:    e = 8'($urandom_range(1, 33));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, m};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One idle cycle: no pulse, not busy, results held.
    task automatic checkIdle(input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, "_done"}, {31'h0, done}, 32'h0);
        checkOutput({tag, "_working"}, {31'h0, working}, 32'h0);
        checkOutput({tag, "_val1"}, val_1, expV1);
        checkOutput({tag, "_val2"}, val_2, expV2);
        checkOutput({tag, "_dir"}, {31'h0, dir}, {31'h0, expDir});
    endtask

    // One full operation with cycle-by-cycle checks. noisy keeps start high
    // with changing operands while busy; dropEn lowers clk_en mid-operation.
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] z, input logic [4:0] i,
                                 input bit noisy, input bit dropEn);
        logic        d;
        logic [31:0] newV1;
        logic [31:0] newV2;
        d     = (z[31] == 1'b0) || (z[30:23] == 8'h0);
        newV1 = modelVal(y, int'(i), d);
        newV2 = modelVal(x, int'(i), ~d);
        current_x = x;
        current_y = y;
        current_z = z;
        iteration = i;
        start     = 1'b1;
        clk_en    = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("accept_working", {31'h0, working}, 32'h0);
        checkOutput("accept_done", {31'h0, done}, 32'h0);
        if (!noisy) start = 1'b0;
        if (dropEn) clk_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (noisy) begin
                current_x = $urandom;
                current_y = $urandom;
                current_z = $urandom;
                iteration = 5'($urandom);
            end
            @(posedge clk);
            #1;
            checkOutput("busy_working", {31'h0, working}, 32'h1);
            checkOutput("busy_done", {31'h0, done}, 32'h0);
            checkOutput("busy_val1_hold", val_1, expV1);
            checkOutput("busy_val2_hold", val_2, expV2);
        end
        @(posedge clk);
        #1;
        expV1  = newV1;
        expV2  = newV2;
        expDir = d;
        checkOutput("result_done", {31'h0, done}, 32'h1);
        checkOutput("result_working", {31'h0, working}, 32'h0);
        checkOutput("result_val1", val_1, expV1);
        checkOutput("result_val2", val_2, expV2);
        checkOutput("result_dir", {31'h0, dir}, {31'h0, expDir});
        start  = 1'b0;
        clk_en = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        clk_en    = 1'b0;
        start     = 1'b0;
        current_x = 32'h0;
        current_y = 32'h0;
        current_z = 32'h0;
        iteration = 5'h0;

        // Reset state while reset is held.
        #2;
        checkOutput("reset_val1", val_1, 32'h0);
        checkOutput("reset_val2", val_2, 32'h0);
        checkOutput("reset_dir", {31'h0, dir}, 32'h0);
        checkOutput("reset_done", {31'h0, done}, 32'h0);
        checkOutput("reset_working", {31'h0, working}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkIdle("post_reset");

        // Reference vectors with fixed expected results.
        applyStimulus(32'h3F800000, 32'h3F000000, 32'h3E800000, 5'd1, 1'b0, 1'b0);
        checkOutput("v20_val1", val_1, 32'hBE800000);
        checkOutput("v20_val2", val_2, 32'h3F000000);
        checkOutput("v20_dir", {31'h0, dir}, 32'h1);
        checkIdle("v20_after");

        applyStimulus(32'h40000000, 32'hBF800000, 32'hBE800000, 5'd3, 1'b0, 1'b1);
        checkOutput("v21_val1", val_1, 32'hBE000000);
        checkOutput("v21_val2", val_2, 32'hBE800000);
        checkOutput("v21_dir", {31'h0, dir}, 32'h0);
        checkIdle("v21_after");

        applyStimulus(32'h02800000, 32'h3F800000, 32'h00000000, 5'd5, 1'b0, 1'b0);
        checkOutput("v22a_val2", val_2, 32'h00000000);
        checkOutput("v22a_dir", {31'h0, dir}, 32'h1);
        applyStimulus(32'h02800000, 32'h3F800000, 32'h00000000, 5'd4, 1'b0, 1'b0);
        checkOutput("v22b_val2", val_2, 32'h00800000);
        checkOutput("v22b_dir", {31'h0, dir}, 32'h1);
        checkIdle("v22_after");

        applyStimulus(32'h7F800000, 32'h7FC00001, 32'h3F800000, 5'd7, 1'b1, 1'b1);
        checkOutput("v23_val2", val_2, 32'h7F800000);
        checkOutput("v23_val1", val_1, 32'h7FC00000);
        checkIdle("v23_after");

        // Start with clk_en low in IDLE must be ignored.
        start  = 1'b1;
        clk_en = 1'b0;
        current_x = 32'h41000000;
        current_y = 32'hC1000000;
        current_z = 32'hBF000000;
        iteration = 5'd2;
        for (int k = 0; k < 4; k++) checkIdle("gated_start");
        start  = 1'b0;
        clk_en = 1'b1;

        // Back-to-back: second start on the edge after the done pulse.
        applyStimulus(32'h3FC00000, 32'h40400000, 32'hBF000000, 5'd2, 1'b0, 1'b0);
        applyStimulus(32'hC0800000, 32'h3E000000, 32'h3F000000, 5'd6, 1'b0, 1'b0);
        checkIdle("b2b_after");

        // Reset pulsed while the operation is in SCALE.
        current_x = 32'h3F800000;
        current_y = 32'h3F800000;
        current_z = 32'hBF800000;
        iteration = 5'd1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        expV1  = 32'h0;
        expV2  = 32'h0;
        expDir = 1'b0;
        checkOutput("midrst_val1", val_1, 32'h0);
        checkOutput("midrst_val2", val_2, 32'h0);
        checkOutput("midrst_dir", {31'h0, dir}, 32'h0);
        checkOutput("midrst_working", {31'h0, working}, 32'h0);
        checkOutput("midrst_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) checkIdle("midrst_idle");
        applyStimulus(32'h40000000, 32'hBF800000, 32'hBE800000, 5'd3, 1'b0, 1'b0);
        checkOutput("midrst_next_val1", val_1, 32'hBE000000);
        checkOutput("midrst_next_val2", val_2, 32'hBE800000);

        // Randomized operations against the model.
        for (int n = 0; n < 60; n++) begin
            applyStimulus(randFloat(), randFloat(), randFloat(), 5'($urandom),
                          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) checkIdle("rand_gap");
        end
        checkIdle("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
